// File: rtl/eth_tx_rr_arbiter.sv
// Packet-granular round-robin mux of NUM_PORTS Avalon-ST TX streams onto one MAC TX stream,
// with a registered output stage and a per-packet beat watchdog that truncates runaway packets.
module eth_tx_rr_arbiter #(
  parameter int unsigned NUM_PORTS   = 3,
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned EMPTY_WIDTH = 5,
  parameter int unsigned MAX_BEATS   = 48
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             in_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_PORTS-1:0]             in_sop,
  input  logic [NUM_PORTS-1:0]             in_eop,
  input  logic [NUM_PORTS*EMPTY_WIDTH-1:0] in_empty,
  input  logic [NUM_PORTS-1:0]             in_error,
  output logic [NUM_PORTS-1:0]             in_ready,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_sop,
  output logic                             out_eop,
  output logic [EMPTY_WIDTH-1:0]           out_empty,
  output logic                             out_error,
  input  logic                             out_ready,
  output logic [$clog2(NUM_PORTS)-1:0]     grant_idx,
  output logic                             busy,
  output logic [15:0]                      trunc_cnt,
  output logic [15:0]                      orphan_cnt
);

  localparam int unsigned GW = $clog2(NUM_PORTS);
  localparam int unsigned BW = $clog2(MAX_BEATS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOCKED = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [GW-1:0]          rr_q, rr_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_sop_q, out_sop_d;
  logic                   out_eop_q, out_eop_d;
  logic [EMPTY_WIDTH-1:0] out_empty_q, out_empty_d;
  logic                   out_error_q, out_error_d;
  logic [15:0]            trunc_q, trunc_d;
  logic [15:0]            orphan_q, orphan_d;

  logic                   slot_free;
  logic [NUM_PORTS-1:0]   orphan_mask;
  logic [16:0]            orphan_inc;
  logic [16:0]            orphan_sum;
  logic                   win_found;
  logic [GW-1:0]          win_idx;
  int unsigned            idx;
  logic [GW-1:0]          nxt_ptr;
  logic                   ready_g;
  logic                   accept;
  logic                   sel_valid, sel_sop, sel_eop, sel_error;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [EMPTY_WIDTH-1:0] sel_empty;

  always_comb begin
    slot_free   = !out_valid_q || out_ready;
    orphan_mask = in_valid & ~in_sop;
    orphan_inc  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      orphan_inc = orphan_inc + 17'(orphan_mask[i]);
    end
    orphan_sum = {1'b0, orphan_q} + orphan_inc;

    // Rotating priority scan: first sop-valid port at or after rr_q wins.
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!win_found && in_valid[idx] && in_sop[idx]) begin
        win_found = 1'b1;
        win_idx   = GW'(idx);
      end
    end

    nxt_ptr   = (32'(grant_q) == NUM_PORTS - 1) ? '0 : grant_q + GW'(1);
    sel_valid = in_valid[grant_q];
    sel_sop   = in_sop[grant_q];
    sel_eop   = in_eop[grant_q];
    sel_error = in_error[grant_q];
    sel_data  = in_data[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    sel_empty = in_empty[32'(grant_q)*EMPTY_WIDTH +: EMPTY_WIDTH];

    ready_g = (state_q == S_DRAIN) || ((state_q == S_LOCKED) && slot_free);
    in_ready = '0;
    if (state_q == S_IDLE) in_ready = orphan_mask;
    else                   in_ready[grant_q] = ready_g;
    accept = sel_valid && ready_g;

    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    beat_d      = beat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_empty_d = out_empty_q;
    out_error_d = out_error_q;
    trunc_d     = trunc_q;
    orphan_d    = orphan_q;

    if (slot_free) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        orphan_d = orphan_sum[16] ? 16'hFFFF : orphan_sum[15:0];
        if (win_found) begin
          state_d = S_LOCKED;
          grant_d = win_idx;
          beat_d  = '0;
        end
      end
      S_LOCKED: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = sel_data;
          out_sop_d   = sel_sop;
          out_eop_d   = sel_eop;
          out_empty_d = sel_empty;
          out_error_d = sel_error;
          if (sel_eop) begin
            state_d = S_IDLE;
            rr_d    = nxt_ptr;
            beat_d  = '0;
          end else if (beat_q == BW'(MAX_BEATS - 1)) begin
            // Watchdog: close the packet on this beat and flag it bad.
            out_eop_d   = 1'b1;
            out_error_d = 1'b1;
            out_empty_d = '0;
            trunc_d     = (trunc_q == 16'hFFFF) ? trunc_q : trunc_q + 16'd1;
            state_d     = S_DRAIN;
            beat_d      = '0;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (accept && sel_eop) begin
          state_d = S_IDLE;
          rr_d    = nxt_ptr;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      grant_q     <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_empty_q <= '0;
      out_error_q <= 1'b0;
      trunc_q     <= '0;
      orphan_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_empty_q <= out_empty_d;
      out_error_q <= out_error_d;
      trunc_q     <= trunc_d;
      orphan_q    <= orphan_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sop    = out_sop_q;
  assign out_eop    = out_eop_q;
  assign out_empty  = out_empty_q;
  assign out_error  = out_error_q;
  assign grant_idx  = grant_q;
  assign busy       = (state_q != S_IDLE);
  assign trunc_cnt  = trunc_q;
  assign orphan_cnt = orphan_q;

endmodule
